// File: rtl/tartaruga_pkg.sv
// Shared decode types and scoreboard definitions.
package tartaruga_pkg;

  // Second ALU operand source.
  typedef enum logic {
    RS2 = 1'b0,
    IMM = 1'b1
  } op_sel_t;

  // Decoder output record.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [3:0]  alu_op;
    logic        write_enable;
    logic [4:0]  addr_rs1;
    logic [4:0]  addr_rs2;
    logic [4:0]  addr_rd;
    op_sel_t     rs2_or_imm;
    logic [31:0] imm;
  } instr_data_t;

  // Scoreboard control states.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_t;

  localparam int SB_MAX_INFLIGHT = 4;

endpackage

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: blocks issue on RAW/WAW hazards against
// outstanding writes, limits in-flight depth, and counts hazard stalls.
module decode_scoreboard
  import tartaruga_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        dec_valid_i,
  input  instr_data_t dec_instr_i,
  output logic        dec_ready_o,
  output logic        issue_valid_o,
  output instr_data_t issue_instr_o,
  input  logic        issue_ready_i,
  input  logic        commit_valid_i,
  input  logic        commit_we_i,
  input  logic [4:0]  commit_rd_i,
  input  logic        flush_i,
  output logic [31:0] stall_cycles_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] INFL_MAX = CNT_W'(MAX_INFLIGHT);

  sb_state_t        r_state, w_state_nxt;
  logic [31:0]      r_pending, w_pending_nxt;
  logic [CNT_W-1:0] r_inflight, w_inflight_nxt;
  logic [31:0]      r_stall;
  logic             w_hazard, w_full, w_run, w_issue, w_commit_ok, w_stall_ev;

  // Hazard check uses registered pending bits only: a commit landing this
  // cycle does not release a waiting instruction until the next cycle.
  always_comb begin
    w_hazard = r_pending[dec_instr_i.addr_rs1]
             | ((dec_instr_i.rs2_or_imm == RS2) & r_pending[dec_instr_i.addr_rs2])
             | (dec_instr_i.write_enable & r_pending[dec_instr_i.addr_rd]);
  end

  assign w_full         = (r_inflight == INFL_MAX);
  assign w_run          = (r_state == RUN);
  assign issue_valid_o  = dec_valid_i & w_run & ~w_hazard & ~w_full;
  assign dec_ready_o    = issue_valid_o & issue_ready_i;
  assign issue_instr_o  = dec_instr_i;
  assign w_issue        = dec_ready_o;
  // A commit with nothing in flight is an error and is dropped.
  assign w_commit_ok    = commit_valid_i & w_run & (r_inflight != '0);
  // Backpressure is not a stall; only hazard or depth limit count.
  assign w_stall_ev     = dec_valid_i & w_run & (w_hazard | w_full);
  assign stall_cycles_o = r_stall;

  // Next control state: FLUSH lasts one cycle unless flush_i is held.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush_i) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = flush_i ? FLUSH : RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Next pending mask: set after clear so a same-register set wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_commit_ok && commit_we_i) w_pending_nxt[commit_rd_i] = 1'b0;
    if (w_issue && dec_instr_i.write_enable) w_pending_nxt[dec_instr_i.addr_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Next in-flight count: issue and commit together cancel out.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_issue && !w_commit_ok)      w_inflight_nxt = r_inflight + CNT_W'(1);
    else if (!w_issue && w_commit_ok) w_inflight_nxt = r_inflight - CNT_W'(1);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  // Tracking registers; flush overrides any same-cycle issue or commit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pending  <= '0;
      r_inflight <= '0;
    end else if (flush_i) begin
      r_pending  <= '0;
      r_inflight <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                         r_stall <= '0;
    else if (w_stall_ev && r_stall != '1) r_stall <= r_stall + 32'd1;
  end

`ifndef SYNTHESIS
  a_commit_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(commit_valid_i && w_run && !flush_i && r_inflight == '0));
`endif

endmodule
